l1dcache_core: RTL and testbench
================================

Name: l1dcache_core

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache.
- Acts as the responder on the l1dcache_core_if core port: it accepts load and store requests from the memory stage and returns load data and a negative acknowledge one cycle later.
- Misses are refilled from a word-wide backing-memory port.
- Stores are forwarded to memory through a single-entry store buffer.

Parameters:
- SETS, 64, number of lines; power of two.
- LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.

Ports:
- clk  in  1  clock
- nRst  in  1  asynchronous active-low reset
- en  in  1  request valid
- enW  in  1  request is a store; ignored unless en=1
- addr  in  30  word address
- mask  in  4  byte-lane enable for stores
- reqData  in  32  store data
- respData  out  32  load data; valid the cycle after the request
- nAck  out  1  request not performed, core must replay; valid the cycle after the request
- memReqValid  out  1  backing-memory request valid
- memReqReady  in  1  backing memory accepts the request
- memReqWe  out  1  1 = word write, 0 = line read
- memReqAddr  out  30  word address; line-aligned for reads
- memReqData  out  32  write data
- memReqMask  out  4  write byte mask
- memRespValid  in  1  one refill beat
- memRespData  in  32  refill word; beats arrive in offset order 0..LINE_WORDS-1

Behaviour:
- Address split: offset = addr[log2(LINE_WORDS)-1:0]; index = next log2(SETS) bits; tag = remaining upper bits.
- Reset (nRst=0, asynchronous):
  - all valid bits cleared, state IDLE, store buffer empty, beat counter 0.
  - respData=0, nAck=0, memReqValid=0, memReqWe=0, memReqAddr=0, memReqData=0, memReqMask=0.
  - Tag and data arrays are not reset.
- Request in cycle N; respData and nAck are registered and valid in N+1. A cycle with en=0 gives nAck=0 in N+1.
- State IDLE, load:
  - Hit: respData = data array word, nAck=0.
  - Miss: nAck=1; latch the line address; go to REFILL_REQ.
- State IDLE, store hit: accepted only if the store buffer is empty or drains in the same cycle (memReqValid & memReqReady & memReqWe).
  - If accepted: bytes selected by mask are written into the line at the end of N; the buffer is loaded with {addr, reqData, mask}; nAck=0.
  - If not accepted: nAck=1 and nothing changes.
- State IDLE, store miss: same buffer rule as a store hit; no array update and no allocation.
- A store with mask=0 is accepted; no bytes change and memory still receives a write with mask 0.
- Store buffer:
  - While full, drives memReqValid=1, memReqWe=1 with the buffered addr, data and mask.
  - Empties on memReqReady; takes priority over refill requests.
- REFILL_REQ:
  - Waits until the store buffer is empty, which preserves read-after-write ordering.
  - Then drives memReqValid=1, memReqWe=0, memReqAddr = line address with offset 0.
  - Goes to REFILL_DATA on memReqReady.
- REFILL_DATA:
  - Each memRespValid writes memRespData at the beat counter offset; the counter wraps to 0 after LINE_WORDS-1.
  - On the last beat: set tag and valid, return to IDLE. The new line is usable from the next cycle.
- Any en=1 request while not in IDLE, including the cycle of the last beat, gives nAck=1 with no side effects (no store, no buffer load).
- A store hit in cycle N followed by a load to the same word in N+1 returns the new data.
- memResp beats outside REFILL_DATA are ignored.
- Reset mid-refill aborts the refill: the line stays invalid and the core replays.

Optional Feature:
- DCACHE_STATS_EN defined:
  - adds outputs hitCount (out, 32) and missCount (out, 32), both reset to 0.
  - Counts are taken on IDLE requests only: hitCount increments on every accepted load or store hit; missCount increments on every load miss.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold load 0x100 -> N+1 nAck=1; memReq read 0x100; 4 beats A0..A3 -> IDLE; replayed load of 0x101 -> respData=A1, nAck=0.
- After the line is resident: store 0x102, mask 0011, data 0xAABBCCDD -> nAck=0; memReq write 0x102/0xAABBCCDD/0011; load 0x102 in the next cycle -> low half of respData is 0xCCDD, upper half is the old A2.
- Two back-to-back stores with memReqReady=0 -> second gets nAck=1; after ready=1, a replay is accepted.
- Load miss while the store buffer is full -> refill read is issued only after the buffer write is accepted.
- Load during REFILL_DATA and in the last-beat cycle -> nAck=1; the same load one cycle later -> hit.
- nRst pulsed after 2 refill beats -> memReqValid=0, load to the same line misses again. With DCACHE_STATS_EN: the first two scenarios give hitCount=3, missCount=1.

Source files
------------

// File: rtl/l1dcache_core.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with a single-entry store buffer.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module l1dcache_core #(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        en,
    input  logic        enW,
    input  logic [29:0] addr,
    input  logic [3:0]  mask,
    input  logic [31:0] reqData,
    output logic [31:0] respData,
    output logic        nAck,
    output logic        memReqValid,
    input  logic        memReqReady,
    output logic        memReqWe,
    output logic [29:0] memReqAddr,
    output logic [31:0] memReqData,
    output logic [3:0]  memReqMask,
    input  logic        memRespValid,
    input  logic [31:0] memRespData
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hitCount,
    output logic [31:0] missCount
`endif
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 30 - OFF_W - IDX_W;
    localparam int LINE_W = 30 - OFF_W;

    typedef enum logic [1:0] {IDLE, REFILL_REQ, REFILL_DATA} state_t;

    state_t             r_state;
    logic [SETS-1:0]    r_valid;
    logic [TAG_W-1:0]   r_tag  [SETS];
    logic [31:0]        r_data [SETS][LINE_WORDS];
    logic [LINE_W-1:0]  r_line;
    logic [OFF_W-1:0]   r_beat;
    logic               r_sb_full;
    logic [29:0]        r_sb_addr;
    logic [31:0]        r_sb_data;
    logic [3:0]         r_sb_mask;

    logic [OFF_W-1:0]   w_off;
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [IDX_W-1:0]   w_line_idx;
    logic [TAG_W-1:0]   w_line_tag;
    logic               w_hit;
    logic               w_drain;
    logic               w_sb_ok;
    logic               w_idle_req;
    logic               w_st_acc;
    logic               w_last;
    logic               w_beat_wr;

    assign w_off      = addr[OFF_W-1:0];
    assign w_idx      = addr[OFF_W +: IDX_W];
    assign w_tag      = addr[29 -: TAG_W];
    assign w_line_idx = r_line[IDX_W-1:0];
    assign w_line_tag = r_line[LINE_W-1 -: TAG_W];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // A full buffer always presents a write, so ready alone means it drains this cycle.
    assign w_drain    = r_sb_full & memReqReady;
    assign w_sb_ok    = ~r_sb_full | w_drain;
    assign w_idle_req = (r_state == IDLE) & en;
    assign w_st_acc   = w_idle_req & enW & w_sb_ok;
    assign w_last     = (r_beat == OFF_W'(LINE_WORDS - 1));
    assign w_beat_wr  = (r_state == REFILL_DATA) & memRespValid;

    always_comb begin
        memReqValid = 1'b0;
        memReqWe    = 1'b0;
        memReqAddr  = '0;
        memReqData  = '0;
        memReqMask  = '0;
        if (r_sb_full) begin
            memReqValid = 1'b1;
            memReqWe    = 1'b1;
            memReqAddr  = r_sb_addr;
            memReqData  = r_sb_data;
            memReqMask  = r_sb_mask;
        end else if (r_state == REFILL_REQ) begin
            memReqValid = 1'b1;
            memReqAddr  = {r_line, {OFF_W{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state   <= IDLE;
            r_valid   <= '0;
            r_line    <= '0;
            r_beat    <= '0;
            r_sb_full <= 1'b0;
            r_sb_addr <= '0;
            r_sb_data <= '0;
            r_sb_mask <= '0;
            respData  <= '0;
            nAck      <= 1'b0;
        end else begin
            nAck <= 1'b0;
            if (w_drain)
                r_sb_full <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en && !enW) begin
                        if (w_hit) begin
                            respData <= r_data[w_idx][w_off];
                        end else begin
                            nAck           <= 1'b1;
                            r_line         <= addr[29:OFF_W];
                            r_valid[w_idx] <= 1'b0;
                            r_state        <= REFILL_REQ;
                        end
                    end else if (en && enW) begin
                        if (w_sb_ok) begin
                            r_sb_full <= 1'b1;
                            r_sb_addr <= addr;
                            r_sb_data <= reqData;
                            r_sb_mask <= mask;
                        end else begin
                            nAck <= 1'b1;
                        end
                    end
                end
                REFILL_REQ: begin
                    nAck <= en;
                    if (!r_sb_full && memReqReady)
                        r_state <= REFILL_DATA;
                end
                default: begin
                    nAck <= en;
                    if (memRespValid) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_last) begin
                            r_valid[w_line_idx] <= 1'b1;
                            r_state             <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Tag and data storage carry no reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if (w_st_acc && w_hit) begin
            for (int unsigned b = 0; b < 4; b++)
                if (mask[b])
                    r_data[w_idx][w_off][8*b +: 8] <= reqData[8*b +: 8];
        end
        if (w_beat_wr) begin
            r_data[w_line_idx][r_beat] <= memRespData;
            if (w_last)
                r_tag[w_line_idx] <= w_line_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            hitCount  <= '0;
            missCount <= '0;
        end else if (w_idle_req) begin
            if (w_hit && (!enW || w_sb_ok))
                hitCount <= hitCount + 32'd1;
            if (!enW && !w_hit)
                missCount <= missCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l1dcache_core.sv
// Self-checking bench for l1dcache_core: scoreboard of expected core responses plus
// direct checks of the backing-memory request port.
module tb_l1dcache_core;

    logic        clk = 1'b0;
    logic        nRst;
    logic        en, enW;
    logic [29:0] addr;
    logic [3:0]  mask;
    logic [31:0] reqData;
    logic [31:0] respData;
    logic        nAck;
    logic        memReqValid, memReqReady, memReqWe;
    logic [29:0] memReqAddr;
    logic [31:0] memReqData;
    logic [3:0]  memReqMask;
    logic        memRespValid;
    logic [31:0] memRespData;
`ifdef DCACHE_STATS_EN
    logic [31:0] hitCount, missCount;
`endif

    typedef struct packed {
        logic        xn;
        logic        cd;
        logic [31:0] xd;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    l1dcache_core #(.SETS(64), .LINE_WORDS(4)) dut (
        .clk          (clk),
        .nRst         (nRst),
        .en           (en),
        .enW          (enW),
        .addr         (addr),
        .mask         (mask),
        .reqData      (reqData),
        .respData     (respData),
        .nAck         (nAck),
        .memReqValid  (memReqValid),
        .memReqReady  (memReqReady),
        .memReqWe     (memReqWe),
        .memReqAddr   (memReqAddr),
        .memReqData   (memReqData),
        .memReqMask   (memReqMask),
        .memRespValid (memRespValid),
        .memRespData  (memRespData)
`ifdef DCACHE_STATS_EN
        ,
        .hitCount     (hitCount),
        .missCount    (missCount)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request cycle and queue the response expected in the following cycle.
    task automatic send(input logic e, input logic w, input logic [29:0] a, input logic [3:0] m,
                        input logic [31:0] d, input logic xn, input logic cd, input logic [31:0] xd);
        en      = e;
        enW     = w;
        addr    = a;
        mask    = m;
        reqData = d;
        sb.push_back('{xn, cd, xd});
        tick();
        en  = 1'b0;
        enW = 1'b0;
    endtask

    task automatic test_reset();
        nRst = 1'b0; en = 1'b0; enW = 1'b0; addr = '0; mask = '0; reqData = '0;
        memReqReady = 1'b1; memRespValid = 1'b0; memRespData = '0;
        #12;
        n_tests++;
        if ({respData, nAck, memReqValid, memReqWe, memReqAddr, memReqData, memReqMask} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs resp=%h nAck=%b rv=%b we=%b a=%h d=%h m=%h required all zero",
                     respData, nAck, memReqValid, memReqWe, memReqAddr, memReqData, memReqMask);
        end
`ifdef DCACHE_STATS_EN
        n_tests++;
        if (hitCount !== 32'd0 || missCount !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counters hit=%0d miss=%0d required 0/0", hitCount, missCount);
        end
`endif
        @(negedge clk);
        nRst = 1'b1;
        tick();
    endtask

    task automatic test_cold_load();
        exp_t e;
        logic [31:0] beat;
        send(1'b1, 1'b0, 30'h100, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        e = sb.pop_front(); n_tests++;
        if (nAck !== e.xn) begin
            n_fail++; $display("FAIL cold_miss_nack got %b required %b", nAck, e.xn);
        end
        n_tests++;
        if (memReqValid !== 1'b1 || memReqWe !== 1'b0 || memReqAddr !== 30'h100) begin
            n_fail++;
            $display("FAIL refill_read got v=%b we=%b a=%h required 1/0/100", memReqValid, memReqWe, memReqAddr);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            beat = 32'hA000_0000 | 32'(i);
            memRespValid = 1'b1;
            memRespData  = beat;
            tick();
        end
        memRespValid = 1'b0;
        send(1'b1, 1'b0, 30'h101, 4'h0, 32'h0, 1'b0, 1'b1, 32'hA000_0001);
        e = sb.pop_front(); n_tests++;
        if (nAck !== e.xn || respData !== e.xd) begin
            n_fail++; $display("FAIL replay_load got nAck=%b data=%h required %b/%h", nAck, respData, e.xn, e.xd);
        end
        send(1'b0, 1'b0, 30'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        e = sb.pop_front(); n_tests++;
        if (nAck !== e.xn) begin
            n_fail++; $display("FAIL idle_nack got %b required %b", nAck, e.xn);
        end
    endtask

    task automatic test_store_hit();
        exp_t e;
        send(1'b1, 1'b1, 30'h102, 4'b0011, 32'hAABB_CCDD, 1'b0, 1'b0, 32'h0);
        e = sb.pop_front(); n_tests++;
        if (nAck !== e.xn) begin
            n_fail++; $display("FAIL store_hit_nack got %b required %b", nAck, e.xn);
        end
        n_tests++;
        if (memReqValid !== 1'b1 || memReqWe !== 1'b1 || memReqAddr !== 30'h102 ||
            memReqData !== 32'hAABB_CCDD || memReqMask !== 4'b0011) begin
            n_fail++;
            $display("FAIL store_write got v=%b we=%b a=%h d=%h m=%b required 1/1/102/aabbccdd/0011",
                     memReqValid, memReqWe, memReqAddr, memReqData, memReqMask);
        end
        send(1'b1, 1'b0, 30'h102, 4'h0, 32'h0, 1'b0, 1'b1, 32'hA000_CCDD);
        e = sb.pop_front(); n_tests++;
        if (nAck !== e.xn || respData !== e.xd) begin
            n_fail++; $display("FAIL store_then_load got nAck=%b data=%h required %b/%h", nAck, respData, e.xn, e.xd);
        end
`ifdef DCACHE_STATS_EN
        n_tests++;
        if (hitCount !== 32'd3 || missCount !== 32'd1) begin
            n_fail++; $display("FAIL stats got hit=%0d miss=%0d required 3/1", hitCount, missCount);
        end
`endif
    endtask

    task automatic test_back_to_back();
        exp_t e;
        memReqReady = 1'b0;
        send(1'b1, 1'b1, 30'h103, 4'hF, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
        e = sb.pop_front(); n_tests++;
        if (nAck !== e.xn) begin
            n_fail++; $display("FAIL b2b_first got nAck=%b required %b", nAck, e.xn);
        end
        send(1'b1, 1'b1, 30'h101, 4'hF, 32'h2222_2222, 1'b1, 1'b0, 32'h0);
        e = sb.pop_front(); n_tests++;
        if (nAck !== e.xn || memReqAddr !== 30'h103 || memReqData !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL b2b_second got nAck=%b a=%h d=%h required %b/103/11111111", nAck, memReqAddr, memReqData, e.xn);
        end
        memReqReady = 1'b1;
        send(1'b1, 1'b1, 30'h101, 4'hF, 32'h2222_2222, 1'b0, 1'b0, 32'h0);
        e = sb.pop_front(); n_tests++;
        if (nAck !== e.xn || memReqWe !== 1'b1 || memReqAddr !== 30'h101 || memReqData !== 32'h2222_2222) begin
            n_fail++;
            $display("FAIL b2b_replay got nAck=%b we=%b a=%h d=%h required %b/1/101/22222222",
                     nAck, memReqWe, memReqAddr, memReqData, e.xn);
        end
        send(1'b1, 1'b0, 30'h101, 4'h0, 32'h0, 1'b0, 1'b1, 32'h2222_2222);
        e = sb.pop_front(); n_tests++;
        if (nAck !== e.xn || respData !== e.xd) begin
            n_fail++; $display("FAIL b2b_load101 got nAck=%b data=%h required %b/%h", nAck, respData, e.xn, e.xd);
        end
        send(1'b1, 1'b0, 30'h103, 4'h0, 32'h0, 1'b0, 1'b1, 32'h1111_1111);
        e = sb.pop_front(); n_tests++;
        if (nAck !== e.xn || respData !== e.xd || memReqValid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_load103 got nAck=%b data=%h rv=%b required %b/%h/0", nAck, respData, memReqValid, e.xn, e.xd);
        end
    endtask

    task automatic test_miss_behind_store();
        exp_t e;
        logic [31:0] beat;
        memReqReady = 1'b0;
        send(1'b1, 1'b1, 30'h205, 4'hF, 32'h3333_3333, 1'b0, 1'b0, 32'h0);
        e = sb.pop_front(); n_tests++;
        if (nAck !== e.xn) begin
            n_fail++; $display("FAIL miss_store got nAck=%b required %b", nAck, e.xn);
        end
        send(1'b1, 1'b0, 30'h204, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        e = sb.pop_front(); n_tests++;
        if (nAck !== e.xn || memReqWe !== 1'b1 || memReqAddr !== 30'h205) begin
            n_fail++;
            $display("FAIL miss_held got nAck=%b we=%b a=%h required %b/1/205", nAck, memReqWe, memReqAddr, e.xn);
        end
        tick();
        n_tests++;
        if (memReqValid !== 1'b1 || memReqWe !== 1'b1) begin
            n_fail++; $display("FAIL read_before_write got v=%b we=%b required 1/1", memReqValid, memReqWe);
        end
        memReqReady = 1'b1;
        tick();
        n_tests++;
        if (memReqValid !== 1'b1 || memReqWe !== 1'b0 || memReqAddr !== 30'h204) begin
            n_fail++;
            $display("FAIL read_after_drain got v=%b we=%b a=%h required 1/0/204", memReqValid, memReqWe, memReqAddr);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            beat = (i == 1) ? 32'h3333_3333 : (32'hB000_0000 | 32'(i));
            memRespValid = 1'b1;
            memRespData  = beat;
            send(1'b1, 1'b0, 30'h205, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
            e = sb.pop_front(); n_tests++;
            if (nAck !== e.xn) begin
                n_fail++; $display("FAIL load_during_refill beat %0d got nAck=%b required %b", i, nAck, e.xn);
            end
        end
        memRespValid = 1'b0;
        send(1'b1, 1'b0, 30'h205, 4'h0, 32'h0, 1'b0, 1'b1, 32'h3333_3333);
        e = sb.pop_front(); n_tests++;
        if (nAck !== e.xn || respData !== e.xd) begin
            n_fail++; $display("FAIL load_after_refill got nAck=%b data=%h required %b/%h", nAck, respData, e.xn, e.xd);
        end
        send(1'b1, 1'b0, 30'h207, 4'h0, 32'h0, 1'b0, 1'b1, 32'hB000_0003);
        e = sb.pop_front(); n_tests++;
        if (nAck !== e.xn || respData !== e.xd) begin
            n_fail++; $display("FAIL last_beat_word got nAck=%b data=%h required %b/%h", nAck, respData, e.xn, e.xd);
        end
    endtask

    task automatic test_reset_mid_refill();
        exp_t e;
        memReqReady = 1'b1;
        send(1'b1, 1'b0, 30'h308, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        e = sb.pop_front(); n_tests++;
        if (nAck !== e.xn) begin
            n_fail++; $display("FAIL rst_first_miss got nAck=%b required %b", nAck, e.xn);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            memRespValid = 1'b1;
            memRespData  = 32'hC000_0000 | 32'(i);
            tick();
        end
        memRespValid = 1'b0;
        nRst = 1'b0;
        #1;
        n_tests++;
        if (memReqValid !== 1'b0 || nAck !== 1'b0 || respData !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_refill_reset got rv=%b nAck=%b resp=%h required 0/0/0", memReqValid, nAck, respData);
        end
        @(negedge clk);
        nRst = 1'b1;
        tick();
        send(1'b1, 1'b0, 30'h308, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        e = sb.pop_front(); n_tests++;
        if (nAck !== e.xn || memReqValid !== 1'b1 || memReqWe !== 1'b0 || memReqAddr !== 30'h308) begin
            n_fail++;
            $display("FAIL miss_after_reset got nAck=%b v=%b we=%b a=%h required %b/1/0/308",
                     nAck, memReqValid, memReqWe, memReqAddr, e.xn);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cold_load();
        test_store_hit();
        test_back_to_back();
        test_miss_behind_store();
        test_reset_mid_refill();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
